// File: rtl/vertex_ranges.sv
// rtl/vertex_ranges.sv - forward range model: T and anchors U/V/W to floor(sqrt) ranges
// One shared squarer and one restoring bit-serial square root, time-multiplexed over the anchors.
module vertex_ranges #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N+1:0] xT,
  input  logic signed [N+1:0] yT,
  input  logic signed [N-1:0] xU,
  input  logic signed [N-1:0] yU,
  input  logic signed [N-1:0] xV,
  input  logic signed [N-1:0] yV,
  input  logic signed [N-1:0] xW,
  input  logic signed [N-1:0] yW,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N:0]   rU,
  output logic signed [N:0]   rV,
  output logic signed [N:0]   rW,
  output logic [2:0]          sat
);

  localparam int DW = 2*N + 4;
  localparam int QW = N + 2;
  localparam int RW = N + 5;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

  typedef enum logic [1:0] {IDLE, SQ, ROOT, DONE} state_t;

  state_t                state;
  logic [1:0]            k;
  logic [CW-1:0]         cnt;
  logic signed [N+1:0]   x_t, y_t;
  logic signed [N-1:0]   ax [3];
  logic signed [N-1:0]   ay [3];
  logic [DW-1:0]         d_reg;
  logic [RW-1:0]         rem;
  logic [QW-1:0]         q;

  logic signed [N-1:0]   xa, ya;
  logic signed [N+2:0]   dx, dy;
  logic [N+2:0]          dx_abs, dy_abs;
  logic [DW-1:0]         dxw, dyw, d_sq;
  logic [RW+1:0]         rem_sh, trial;
  logic                  ge;
  logic [RW-1:0]         rem_next;
  logic [QW-1:0]         q_next;
  logic                  sat_next;
  logic [N:0]            range_next;

  always_comb begin
    xa = ax[0];
    ya = ay[0];
    case (k)
      2'd1:    begin xa = ax[1]; ya = ay[1]; end
      2'd2:    begin xa = ax[2]; ya = ay[2]; end
      default: begin xa = ax[0]; ya = ay[0]; end
    endcase
  end

  // Squares are taken of magnitudes so the sum is exact in DW unsigned bits.
  always_comb begin
    dx     = {x_t[N+1], x_t} - {{3{xa[N-1]}}, xa};
    dy     = {y_t[N+1], y_t} - {{3{ya[N-1]}}, ya};
    dx_abs = dx[N+2] ? -dx : dx;
    dy_abs = dy[N+2] ? -dy : dy;
    dxw    = {{(DW-N-3){1'b0}}, dx_abs};
    dyw    = {{(DW-N-3){1'b0}}, dy_abs};
    d_sq   = dxw * dxw + dyw * dyw;
  end

  // One restoring root digit: bring down two radicand bits, try 4q+1.
  always_comb begin
    rem_sh     = {rem, d_reg[DW-1 -: 2]};
    trial      = {{(RW-QW){1'b0}}, q, 2'b01};
    ge         = (rem_sh >= trial);
    rem_next   = ge ? RW'(rem_sh - trial) : RW'(rem_sh);
    q_next     = {q[QW-2:0], ge};
    sat_next   = |q_next[QW-1:N];
    range_next = sat_next ? {1'b0, {N{1'b1}}} : {1'b0, q_next[N-1:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      rU        <= '0;
      rV        <= '0;
      rW        <= '0;
      sat       <= '0;
      k         <= '0;
      cnt       <= '0;
      d_reg     <= '0;
      rem       <= '0;
      q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            x_t      <= xT;
            y_t      <= yT;
            ax[0]    <= xU;
            ay[0]    <= yU;
            ax[1]    <= xV;
            ay[1]    <= yV;
            ax[2]    <= xW;
            ay[2]    <= yW;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= SQ;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SQ: begin
          d_reg <= d_sq;
          rem   <= '0;
          q     <= '0;
          cnt   <= '0;
          state <= ROOT;
        end
        ROOT: begin
          d_reg <= {d_reg[DW-3:0], 2'b00};
          rem   <= rem_next;
          q     <= q_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            case (k)
              2'd0:    begin rU <= range_next; sat[0] <= sat_next; end
              2'd1:    begin rV <= range_next; sat[1] <= sat_next; end
              default: begin rW <= range_next; sat[2] <= sat_next; end
            endcase
            if (k == 2'd2) begin
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              k     <= k + 2'd1;
              state <= SQ;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_ranges.sv
// tb/tb_vertex_ranges.sv - self-checking bench for vertex_ranges
module tb_vertex_ranges;
  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n, in_valid, in_ready, out_valid, out_ready;
  logic signed [N+1:0] xT, yT;
  logic signed [N-1:0] xU, yU, xV, yV, xW, yW;
  logic signed [N:0]   rU, rV, rW;
  logic [2:0]          sat;

  vertex_ranges #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .xT(xT), .yT(yT), .xU(xU), .yU(yU), .xV(xV), .yV(yV), .xW(xW), .yW(yW),
    .out_valid(out_valid), .out_ready(out_ready),
    .rU(rU), .rV(rV), .rW(rW), .sat(sat)
  );

  typedef struct {
    int xt, yt, xu, yu, xv, yv, xw, yw;
    int ru, rv, rw, s;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Range = floor of the Euclidean distance, found by plain integer search.
  function automatic int ref_range(input int xt, input int yt, input int xa, input int ya,
                                   output int s);
    longint d, r;
    d = longint'(xt - xa) * (xt - xa) + longint'(yt - ya) * (yt - ya);
    r = 0;
    while ((r + 1) * (r + 1) <= d) r++;
    s = (r > 255) ? 1 : 0;
    return (r > 255) ? 255 : int'(r);
  endfunction

  function automatic vec_t with_model(input vec_t v);
    vec_t o;
    int s0, s1, s2;
    o = v;
    o.ru = ref_range(v.xt, v.yt, v.xu, v.yu, s0);
    o.rv = ref_range(v.xt, v.yt, v.xv, v.yv, s1);
    o.rw = ref_range(v.xt, v.yt, v.xw, v.yw, s2);
    o.s  = s0 + 2 * s1 + 4 * s2;
    return o;
  endfunction

  task automatic drive(input vec_t v);
    xT = (N+2)'(v.xt); yT = (N+2)'(v.yt);
    xU = N'(v.xu); yU = N'(v.yu);
    xV = N'(v.xv); yV = N'(v.yv);
    xW = N'(v.xw); yW = N'(v.yw);
  endtask

  task automatic scramble();
    xT = (N+2)'($urandom); yT = (N+2)'($urandom);
    xU = N'($urandom); yU = N'($urandom); xV = N'($urandom);
    yV = N'($urandom); xW = N'($urandom); yW = N'($urandom);
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic accept(input vec_t v);
    int t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    check("in_ready_before_accept", int'(in_ready), 1);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_out(input int start, output int lat);
    lat = start;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("out_valid_seen", int'(out_valid), 1);
  endtask

  task automatic check_out(input string tag, input vec_t v);
    check({tag, "_rU"}, int'(rU), v.ru);
    check({tag, "_rV"}, int'(rV), v.rv);
    check({tag, "_rW"}, int'(rW), v.rw);
    check({tag, "_sat"}, int'(sat), v.s);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", int'(out_valid), 0);
    check("in_ready_after_release", int'(in_ready), 1);
  endtask

  vec_t tbl[4];
  vec_t rv;
  int   lat, bad;
  int   acc[$];

  initial begin
    tbl[0] = '{xt:0,   yt:0,   xu:3,    yu:4,    xv:-6,   yv:8,  xw:0,    yw:0,
               ru:5,   rv:10,  rw:0,    s:0};
    tbl[1] = '{xt:0,   yt:0,   xu:1,    yu:1,    xv:2,    yv:3,  xw:-15,  yw:0,
               ru:1,   rv:3,   rw:15,   s:0};
    tbl[2] = '{xt:300, yt:0,   xu:44,   yu:0,    xv:45,   yv:0,  xw:-128, yw:0,
               ru:255, rv:255, rw:255,  s:5};
    tbl[3] = '{xt:511, yt:511, xu:-128, yu:-128, xv:0,    yv:0,  xw:127,  yw:127,
               ru:255, rv:255, rw:255,  s:7};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(tbl[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_ranges", int'(rU) + int'(rV) + int'(rW), 0);
    check("rst_sat", int'(sat), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 4; i++) begin
      accept(tbl[i]);
      wait_out(0, lat);
      check($sformatf("tbl%0d_latency", i), lat, 33);
      check_out($sformatf("tbl%0d", i), tbl[i]);
      release_out();
    end

    // Backpressure, with an early out_ready pulse while out_valid is low.
    accept(tbl[0]);
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    out_ready = 1'b0;
    wait_out(20, lat);
    check("bp_latency", lat, 33);
    drive(tbl[1]);
    in_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!out_valid || in_ready || rU != 5 || rV != 10 || rW != 0 || sat != 0) bad++;
    end
    check("bp_stable_cycles", bad, 0);
    in_valid = 1'b0;
    check_out("bp", tbl[0]);
    release_out();
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid || !in_ready) bad++;
    end
    check("bp_ignored_input", bad, 0);

    // Reset at edge 15 of a transaction.
    accept(tbl[2]);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_ranges", int'(rU) + int'(rV) + int'(rW), 0);
    check("midrst_sat", int'(sat), 0);
    check("midrst_in_ready_low", int'(in_ready), 0);
    @(negedge clk);
    check("midrst_in_ready_high", int'(in_ready), 1);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("midrst_no_pulse", bad, 0);
    accept(tbl[0]);
    wait_out(0, lat);
    check_out("postrst", tbl[0]);
    release_out();

    // Back-to-back throughput.
    drive(tbl[1]);
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      logic r;
      r = in_ready;
      @(posedge clk);
      if (r) acc.push_back(c);
      @(negedge clk);
      if (acc.size() >= 2) break;
    end
    in_valid = 1'b0;
    check("b2b_accepts", acc.size(), 2);
    if (acc.size() == 2) check("b2b_period", acc[1] - acc[0], 35);
    wait_out(0, lat);
    check_out("b2b", tbl[1]);
    @(negedge clk);
    out_ready = 1'b0;

    // Randomized vectors against the distance model.
    for (int i = 0; i < 20; i++) begin
      rv.xt = int'($urandom_range(1023)) - 512;
      rv.yt = int'($urandom_range(1023)) - 512;
      rv.xu = int'($urandom_range(255)) - 128;
      rv.yu = int'($urandom_range(255)) - 128;
      rv.xv = int'($urandom_range(255)) - 128;
      rv.yv = int'($urandom_range(255)) - 128;
      rv.xw = int'($urandom_range(255)) - 128;
      rv.yw = int'($urandom_range(255)) - 128;
      if (i < 10) begin
        rv.xt = rv.xt / 4;
        rv.yt = rv.yt / 4;
      end
      rv = with_model(rv);
      accept(rv);
      wait_out(0, lat);
      check_out($sformatf("rnd%0d", i), rv);
      release_out();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
